// File: rtl/db_arbiter_pkg.sv
// Shared CPU break-state encodings, bus widths and arbiter FSM type for the data-break channel.
// Every db_arbiter file takes its codes from here so the CPU and the arbiter agree.
package db_arbiter_pkg;

  localparam int ADDR_W  = 15;
  localparam int DATA_W  = 12;
  localparam int STATE_W = 5;

  // CPU major-state codes (one-hot, matching the CPU's state register)
  localparam logic [STATE_W-1:0] F1  = 5'b00001;
  localparam logic [STATE_W-1:0] DB1 = 5'b01000;
  localparam logic [STATE_W-1:0] DB2 = 5'b10000;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    BREAK,
    XFER
  } arb_state_e;

endpackage

// File: rtl/db_arbiter_if.sv
// Requester and CPU break-channel signals of db_arbiter; slave = arbiter view, master = environment view.
// Vector bit N-1 is the PDP-8 bit 0 (most significant) of each word.
interface db_arbiter_if
  import db_arbiter_pkg::*;
#(
  parameter int NREQ = 2
);
  logic                clear;
  logic [STATE_W-1:0]  state;
  logic                break_in_prog;

  logic [NREQ-1:0]     req;
  logic [ADDR_W-1:0]   req_addr   [NREQ];
  logic [NREQ-1:0]     req_to_mem;
  logic [DATA_W-1:0]   req_wdata  [NREQ];
  logic [NREQ-1:0]     ack;
  logic [NREQ-1:0]     err;
  logic [DATA_W-1:0]   rdata;

  logic                data_break;
  logic [ADDR_W-1:0]   dmaAddr;
  logic                to_mem;
  logic [DATA_W-1:0]   dmaDOUT;
  logic [DATA_W-1:0]   dmaDIN;

  modport slave (
    input  clear, state, break_in_prog, req, req_addr, req_to_mem, req_wdata, dmaDIN,
    output ack, err, rdata, data_break, dmaAddr, to_mem, dmaDOUT
  );

  modport master (
    output clear, state, break_in_prog, req, req_addr, req_to_mem, req_wdata, dmaDIN,
    input  ack, err, rdata, data_break, dmaAddr, to_mem, dmaDOUT
  );

endinterface

// File: rtl/db_arbiter_rr_select.sv
// Round-robin pick: first asserted req at or after ptr, wrapping mod NREQ. Purely combinational,
// no backpressure; valid low when nothing is pending.
module db_arbiter_rr_select #(
  parameter  int NREQ = 2,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            vld,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] cand;

  // Scan from farthest to nearest so the candidate closest to ptr is the last one written.
  always_comb begin
    vld  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (req[cand]) begin
        vld = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/db_arbiter.sv
// Data-break arbiter: round-robin grant, data_break 2 cycles after req, ack/err 1 cycle after DB2/abort.
// Requesters hold req until ack/err; the CPU paces the cycle through DB1/DB2, with a watchdog on DB1.
module db_arbiter
  import db_arbiter_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  db_arbiter_if.slave bus
);

  localparam int IW = $clog2(NREQ);
  localparam int WW = $clog2(TIMEOUT + 1);

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     win_q, win_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [WW-1:0]     wdog_q, wdog_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              to_mem_q, to_mem_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              data_break_q, data_break_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [NREQ-1:0]   err_q, err_d;

  logic              sel_vld;
  logic [IW-1:0]     sel_idx;
  logic              abort;

  db_arbiter_rr_select #(.NREQ(NREQ)) u_rr_select (
    .req (bus.req),
    .ptr (rr_ptr_q),
    .vld (sel_vld),
    .idx (sel_idx)
  );

  // Only a break the CPU has not yet committed to may be cancelled by clear.
  assign abort = bus.clear && !bus.break_in_prog;

  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    rr_ptr_d     = rr_ptr_q;
    wdog_d       = wdog_q;
    addr_d       = addr_q;
    to_mem_d     = to_mem_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    data_break_d = data_break_q;
    ack_d        = '0;
    err_d        = '0;

    unique case (state_q)
      IDLE: begin
        if (sel_vld) begin
          win_d   = sel_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        addr_d   = bus.req_addr[win_q];
        to_mem_d = bus.req_to_mem[win_q];
        wdata_d  = bus.req_wdata[win_q];
        wdog_d   = '0;
        if (abort) begin
          err_d[win_q] = 1'b1;
          state_d      = IDLE;
        end else begin
          data_break_d = 1'b1;
          state_d      = BREAK;
        end
      end
      BREAK: begin
        // DB1 means the CPU has taken the break, so it outranks both clear and the watchdog.
        if (bus.state == DB1) begin
          data_break_d = 1'b0;
          state_d      = XFER;
        end else if (abort || wdog_q == WW'(TIMEOUT - 1)) begin
          data_break_d = 1'b0;
          err_d[win_q] = 1'b1;
          state_d      = IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      XFER: begin
        if (bus.state == DB2) begin
          if (!to_mem_q) begin
            rdata_d = bus.dmaDIN;
          end
          ack_d[win_q] = 1'b1;
          rr_ptr_d     = (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      win_q        <= '0;
      rr_ptr_q     <= '0;
      wdog_q       <= '0;
      addr_q       <= '0;
      to_mem_q     <= 1'b0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      data_break_q <= 1'b0;
      ack_q        <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      rr_ptr_q     <= rr_ptr_d;
      wdog_q       <= wdog_d;
      addr_q       <= addr_d;
      to_mem_q     <= to_mem_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      data_break_q <= data_break_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
    end
  end

  assign bus.ack        = ack_q;
  assign bus.err        = err_q;
  assign bus.rdata      = rdata_q;
  assign bus.data_break = data_break_q;
  assign bus.dmaAddr    = addr_q;
  assign bus.to_mem     = to_mem_q;
  assign bus.dmaDOUT    = wdata_q;

endmodule

// File: doc/db_arbiter.md
# db_arbiter

Data-break (DMA) arbiter and sequencer sharing the CPU's single data-break channel among NREQ peripheral requesters (RK8E disk controller, future TD8E/console DMA). Selects one pending requester round-robin, drives the CPU data-break request, address and direction, and waits for the CPU to reach the DB1/DB2 break states. It then returns read data and a one-cycle acknowledge to the winner. It sits between the peripherals' dmaAddr/data_break/to_disk outputs and the CPU's break inputs.

## Interface
- NREQ, 2: number of requesters, 2..4.
- TIMEOUT, 1023: max cycles to wait for DB1 after raising data_break before aborting.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- clear  in  1  IOCLR/CAF; abort pending (not in-progress) break
- state  in  5  CPU major state; DB1/DB2 codes from shared package
- break_in_prog  in  1  CPU has committed to the current break cycle
- req  in  NREQ  per-requester break request, level
- req_addr  in  15 x NREQ (unpacked [0:14])  15-bit extended memory address
- req_to_mem  in  NREQ  1 = write memory (peripheral->memory), 0 = read memory
- req_wdata  in  12 x NREQ ([0:11])  data to write
- ack  out  NREQ  one-cycle pulse, break completed for that requester
- err  out  NREQ  one-cycle pulse, break aborted (timeout or clear)
- rdata  out  12 ([0:11])  memory read data, valid in ack cycle, held until next ack
- data_break  out  1  break request to CPU
- dmaAddr  out  15 ([0:14])  break address to CPU
- to_mem  out  1  break direction to CPU
- dmaDOUT  out  12  write data to memory
- dmaDIN  in  12  memory read data from CPU

## Operation
- FSM states: IDLE, GRANT, BREAK, XFER.
- IDLE: if any req, select the first asserted index starting at rr_ptr (wrapping mod NREQ) -> GRANT. No req: stay.
- GRANT: latch winner index, req_addr, req_to_mem, req_wdata into registers; clear watchdog -> BREAK. Later changes to requester inputs are ignored until ack/err.
- BREAK: data_break=1 with latched dmaAddr/to_mem/dmaDOUT. On state==DB1 -> XFER, data_break drops same edge. Watchdog hits TIMEOUT without DB1 -> err[winner] pulse, -> IDLE.
- XFER: wait for state==DB2; on that cycle latch rdata<=dmaDIN (read only; rdata unchanged for writes), pulse ack[winner], rr_ptr<=winner+1 mod NREQ -> IDLE.
- Requester must hold req until ack/err; req dropped after GRANT does not cancel the cycle. Same requester may re-request immediately; it is served again only after other pending requesters.
- clear: in GRANT or BREAK with break_in_prog=0 -> err[winner], data_break=0, -> IDLE. In XFER, or with break_in_prog=1, the cycle completes normally. rr_ptr is not reset by clear.
- Simultaneous DB1 and watchdog expiry: DB1 wins.
- Only one of ack/err per grant; never both, never to a non-winner.

## Timing
- Reset values: data_break=0, dmaAddr=0, to_mem=0, dmaDOUT=0, rdata=0, ack=0, err=0, rr_ptr=0, FSM=IDLE. Reset mid-break drops data_break on the next edge with no ack/err.
- req seen in IDLE -> data_break high 2 cycles later (IDLE->GRANT->BREAK registered output).
- data_break low on the cycle after state==DB1 is sampled.
- ack registered: asserts the cycle after state==DB2 is sampled; IDLE re-entry same cycle; next grant earliest 1 cycle after ack.
- Minimum request-to-ack: 2 + CPU latency to DB1 + 1 + DB1->DB2 latency.
- Watchdog counter width clog2(TIMEOUT+1); counts BREAK cycles only.

## Structure
- DB1, DB2, F1 state encodings and the arbiter FSM enum go in the shared parameters/types package; no local copies.
- Round-robin selection is a natural combinational sub-module `rr_select` (req, ptr -> valid, index).
- RK8E's own data_break/dmaAddr/to_disk logic connects as requester 0.

## Test plan
- Single write: req[0]=1, addr 15'o12345, to_mem=1, wdata 12'o7070 -> data_break 2 cycles later, dmaAddr=15'o12345, dmaDOUT=12'o7070; DB1 then DB2 -> ack[0] single pulse, data_break already low.
- Single read: req[1], addr 15'o00200, to_mem=0, dmaDIN=12'o4321 during DB2 -> ack[1], rdata=12'o4321 held after.
- Fairness: req[0] and req[1] held continuously with NREQ=2 -> grants alternate 0,1,0,1 over 4 breaks; rr_ptr=0 after reset so 0 first.
- Timeout: TIMEOUT=8, req[0], never DB1 -> err[0] after 8 BREAK cycles, data_break low, no ack; a subsequent req[1] is served normally.
- Clear: clear in BREAK with break_in_prog=0 -> err pulse, idle; clear with break_in_prog=1 -> cycle completes with ack.
- Reset in XFER -> all outputs to reset values next cycle, no ack/err emitted.
